// File: rtl/cayde_ctrl.sv
// cayde_ctrl: multi-cycle instruction sequencer for the cayde RISC-V core.
// Owns the PC, the instruction register, the retired-instruction counter and
// the sticky trap record, and steps each instruction through
// fetch -> decode -> execute -> (memory) -> writeback.
module cayde_ctrl #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  // instruction memory handshake
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // decoder interface
  output logic [31:0] instr,
  input  logic        dec_illegal,
  input  logic        dec_rf_we,
  input  logic        dec_mem_rd,
  input  logic        dec_mem_wr,
  input  logic [31:0] pc_next,
  // execute / data memory / register file strobes
  output logic        alu_en,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  output logic        rf_we,
  output logic        retire,
  // architectural status
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] trap_pc
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] CAUSE_NONE      = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL   = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN  = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_FETCH_WAIT,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_MEM_WAIT,
    S_WRITEBACK,
    S_TRAP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic        trap_q, trap_d;
  logic [1:0]  trap_cause_q, trap_cause_d;
  logic [31:0] trap_pc_q, trap_pc_d;

  // Ungated strobe decodes; reset masking is applied at the output.
  logic imem_req_s;
  logic alu_en_s;
  logic dmem_req_s;
  logic dmem_we_s;
  logic rf_we_s;
  logic retire_s;

  // State and architectural registers; reset drops everything immediately.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= S_FETCH;
      pc_q         <= BOOT_ADDR;
      instr_q      <= NOP_INSTR;
      instret_q    <= 32'd0;
      trap_q       <= 1'b0;
      trap_cause_q <= CAUSE_NONE;
      trap_pc_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instret_q    <= instret_d;
      trap_q       <= trap_d;
      trap_cause_q <= trap_cause_d;
      trap_pc_q    <= trap_pc_d;
    end
  end

  // Next-state, register updates and Moore strobe decode.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    instret_d    = instret_q;
    trap_d       = trap_q;
    trap_cause_d = trap_cause_q;
    trap_pc_d    = trap_pc_q;
    imem_req_s   = 1'b0;
    alu_en_s     = 1'b0;
    dmem_req_s   = 1'b0;
    dmem_we_s    = 1'b0;
    rf_we_s      = 1'b0;
    retire_s     = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req_s = 1'b1;
        if (imem_gnt) begin
          state_d = S_FETCH_WAIT;
        end
      end

      S_FETCH_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (dec_illegal) begin
          state_d      = S_TRAP;
          trap_d       = 1'b1;
          trap_cause_d = CAUSE_ILLEGAL;
          trap_pc_d    = pc_q;
        end else begin
          state_d = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        alu_en_s = 1'b1;
        state_d  = (dec_mem_rd || dec_mem_wr) ? S_MEM : S_WRITEBACK;
      end

      S_MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = dec_mem_wr;
        if (dmem_gnt) begin
          state_d = S_MEM_WAIT;
        end
      end

      S_MEM_WAIT: begin
        // Loads and stores both finish on rvalid (data or store ack).
        if (dmem_rvalid) begin
          state_d = S_WRITEBACK;
        end
      end

      S_WRITEBACK: begin
        if (pc_next[1:0] != 2'b00) begin
          // Misaligned target: nothing is committed, the PC stays on the
          // faulting instruction.
          state_d      = S_TRAP;
          trap_d       = 1'b1;
          trap_cause_d = CAUSE_MISALIGN;
          trap_pc_d    = pc_q;
        end else begin
          rf_we_s   = dec_rf_we;
          retire_s  = 1'b1;
          pc_d      = pc_next;
          instret_d = instret_q + 32'd1;
          state_d   = S_FETCH;
        end
      end

      S_TRAP: begin
        // Absorbing: only reset leaves this state, no requests are issued.
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Strobes are forced low for as long as reset is held, including the
  // partial cycle in which it is asserted.
  assign imem_req   = imem_req_s & ~rst_in;
  assign alu_en     = alu_en_s   & ~rst_in;
  assign dmem_req   = dmem_req_s & ~rst_in;
  assign dmem_we    = dmem_we_s  & ~rst_in;
  assign rf_we      = rf_we_s    & ~rst_in;
  assign retire     = retire_s   & ~rst_in;

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign instr      = instr_q;
  assign instret    = instret_q;
  assign trap       = trap_q;
  assign trap_cause = trap_cause_q;
  assign trap_pc    = trap_pc_q;

endmodule

// File: tb/tb_cayde_ctrl.sv
// tb_cayde_ctrl: directed bench for the cayde sequencer. Each instruction is
// expanded into a per-cycle timeline (inputs to drive plus expected outputs)
// from handshake delays and the instruction's class; a single compare task
// checks every cycle of that timeline against the DUT.
module tb_cayde_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        dec_illegal;
  logic        dec_rf_we;
  logic        dec_mem_rd;
  logic        dec_mem_wr;
  logic [31:0] pc_next;
  logic        alu_en;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic        rf_we;
  logic        retire;
  logic [31:0] pc;
  logic [31:0] instret;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] trap_pc;

  always #5 clk_in = ~clk_in;

  cayde_ctrl dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .dec_illegal (dec_illegal),
    .dec_rf_we   (dec_rf_we),
    .dec_mem_rd  (dec_mem_rd),
    .dec_mem_wr  (dec_mem_wr),
    .pc_next     (pc_next),
    .alu_en      (alu_en),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .rf_we       (rf_we),
    .retire      (retire),
    .pc          (pc),
    .instret     (instret),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .trap_pc     (trap_pc)
  );

  typedef struct {
    // stimulus for this cycle
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic        dec_illegal;
    logic        dec_rf_we;
    logic        dec_mem_rd;
    logic        dec_mem_wr;
    logic [31:0] pc_next;
    // expected outputs in this cycle
    logic        e_imem_req;
    logic        e_dmem_req;
    logic        e_dmem_we;
    logic        e_alu_en;
    logic        e_rf_we;
    logic        e_retire;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_instret;
    logic        e_trap;
    logic [1:0]  e_cause;
    logic [31:0] e_trap_pc;
  } cyc_t;

  cyc_t tl[$];

  int checks = 0;
  int failures = 0;
  int cyc_no = 0;

  // architectural model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_instret;
  logic        m_trap;
  logic [1:0]  m_cause;
  logic [31:0] m_trap_pc;

  // decoder flags of the instruction currently being built
  logic        cur_ill, cur_rfwe, cur_mrd, cur_mwr;
  logic [31:0] cur_pnext;

  task automatic model_reset();
    m_pc      = 32'h0000_0000;
    m_instr   = 32'h0000_0013;
    m_instret = 32'd0;
    m_trap    = 1'b0;
    m_cause   = 2'b00;
    m_trap_pc = 32'd0;
  endtask

  // Idle cycle; decoder inputs carry either junk (outside the window where
  // the sequencer may look at them) or the current instruction's flags.
  function automatic cyc_t blank(input bit dec_on);
    cyc_t c;
    c.imem_gnt    = 1'b0;
    c.imem_rvalid = 1'b0;
    c.imem_rdata  = 32'hDEAD_BEEF;
    c.dmem_gnt    = 1'b0;
    c.dmem_rvalid = 1'b0;
    if (dec_on) begin
      c.dec_illegal = cur_ill;
      c.dec_rf_we   = cur_rfwe;
      c.dec_mem_rd  = cur_mrd;
      c.dec_mem_wr  = cur_mwr;
      c.pc_next     = cur_pnext;
    end else begin
      c.dec_illegal = 1'b1;
      c.dec_rf_we   = 1'b1;
      c.dec_mem_rd  = 1'b1;
      c.dec_mem_wr  = 1'b1;
      c.pc_next     = 32'h0000_0003;
    end
    c.e_imem_req = 1'b0;
    c.e_dmem_req = 1'b0;
    c.e_dmem_we  = 1'b0;
    c.e_alu_en   = 1'b0;
    c.e_rf_we    = 1'b0;
    c.e_retire   = 1'b0;
    c.e_pc       = m_pc;
    c.e_instr    = m_instr;
    c.e_instret  = m_instret;
    c.e_trap     = m_trap;
    c.e_cause    = m_cause;
    c.e_trap_pc  = m_trap_pc;
    return c;
  endfunction

  // Expand one instruction into its cycle timeline. wb_off is the 1-based
  // cycle of the retire pulse, or -1 when the instruction traps.
  task automatic add_instr(input int ig, input int ir, input logic [31:0] rdata,
                           input logic ill, input logic rfwe, input logic mrd,
                           input logic mwr, input int dg, input int dr,
                           input logic [31:0] pnext, output int wb_off);
    cyc_t c;
    int n;
    n = 0;
    wb_off = -1;
    cur_ill = ill; cur_rfwe = rfwe; cur_mrd = mrd; cur_mwr = mwr; cur_pnext = pnext;
    for (int i = 0; i < ig; i++) begin
      c = blank(0); c.e_imem_req = 1'b1; tl.push_back(c); n++;
    end
    c = blank(0); c.e_imem_req = 1'b1; c.imem_gnt = 1'b1; tl.push_back(c); n++;
    for (int i = 0; i < ir; i++) begin
      c = blank(0); tl.push_back(c); n++;
    end
    c = blank(0); c.imem_rvalid = 1'b1; c.imem_rdata = rdata; tl.push_back(c); n++;
    m_instr = rdata;
    c = blank(1); tl.push_back(c); n++;
    if (ill) begin
      m_trap = 1'b1; m_cause = 2'b01; m_trap_pc = m_pc;
      return;
    end
    c = blank(1); c.e_alu_en = 1'b1; tl.push_back(c); n++;
    if (mrd || mwr) begin
      for (int i = 0; i < dg; i++) begin
        c = blank(1); c.e_dmem_req = 1'b1; c.e_dmem_we = mwr; tl.push_back(c); n++;
      end
      c = blank(1); c.e_dmem_req = 1'b1; c.e_dmem_we = mwr; c.dmem_gnt = 1'b1;
      tl.push_back(c); n++;
      for (int i = 0; i < dr; i++) begin
        c = blank(1); tl.push_back(c); n++;
      end
      c = blank(1); c.dmem_rvalid = 1'b1; tl.push_back(c); n++;
    end
    c = blank(1); n++;
    if (pnext[1:0] != 2'b00) begin
      tl.push_back(c);
      m_trap = 1'b1; m_cause = 2'b10; m_trap_pc = m_pc;
    end else begin
      c.e_rf_we = rfwe; c.e_retire = 1'b1; tl.push_back(c);
      m_pc = pnext; m_instret = m_instret + 32'd1; wb_off = n;
    end
  endtask

  // Parked cycles with every handshake input asserted; all must be ignored.
  task automatic add_trap(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank(0);
      c.imem_gnt = 1'b1; c.imem_rvalid = 1'b1; c.dmem_gnt = 1'b1; c.dmem_rvalid = 1'b1;
      tl.push_back(c);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc_no, act, exp);
    end
  endtask

  task automatic compare(input cyc_t c);
    chk("imem_req",   {31'd0, imem_req},   {31'd0, c.e_imem_req});
    chk("imem_addr",  imem_addr,           c.e_pc);
    chk("dmem_req",   {31'd0, dmem_req},   {31'd0, c.e_dmem_req});
    chk("dmem_we",    {31'd0, dmem_we},    {31'd0, c.e_dmem_we});
    chk("alu_en",     {31'd0, alu_en},     {31'd0, c.e_alu_en});
    chk("rf_we",      {31'd0, rf_we},      {31'd0, c.e_rf_we});
    chk("retire",     {31'd0, retire},     {31'd0, c.e_retire});
    chk("pc",         pc,                  c.e_pc);
    chk("instr",      instr,               c.e_instr);
    chk("instret",    instret,             c.e_instret);
    chk("trap",       {31'd0, trap},       {31'd0, c.e_trap});
    chk("trap_cause", {30'd0, trap_cause}, {30'd0, c.e_cause});
    chk("trap_pc",    trap_pc,             c.e_trap_pc);
  endtask

  task automatic drive(input cyc_t c);
    imem_gnt    = c.imem_gnt;
    imem_rvalid = c.imem_rvalid;
    imem_rdata  = c.imem_rdata;
    dmem_gnt    = c.dmem_gnt;
    dmem_rvalid = c.dmem_rvalid;
    dec_illegal = c.dec_illegal;
    dec_rf_we   = c.dec_rf_we;
    dec_mem_rd  = c.dec_mem_rd;
    dec_mem_wr  = c.dec_mem_wr;
    pc_next     = c.pc_next;
  endtask

  task automatic drive_idle();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    dec_illegal = 1'b0; dec_rf_we = 1'b0; dec_mem_rd = 1'b0; dec_mem_wr = 1'b0;
    pc_next = 32'd0;
  endtask

  // Called on a falling edge; plays n timeline cycles, ends on a falling edge.
  task automatic run_tl(input int n);
    cyc_t c;
    for (int k = 0; k < n; k++) begin
      c = tl.pop_front();
      drive(c);
      #1;
      compare(c);
      cyc_no++;
      @(negedge clk_in);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_dmem_we",  {31'd0, dmem_we},  32'd0);
    chk("rst_alu_en",   {31'd0, alu_en},   32'd0);
    chk("rst_rf_we",    {31'd0, rf_we},    32'd0);
    chk("rst_retire",   {31'd0, retire},   32'd0);
    chk("rst_pc",       pc,                32'h0000_0000);
    chk("rst_instr",    instr,             32'h0000_0013);
    chk("rst_instret",  instret,           32'd0);
    chk("rst_trap",     {31'd0, trap},     32'd0);
    chk("rst_cause",    {30'd0, trap_cause}, 32'd0);
    chk("rst_trap_pc",  trap_pc,           32'd0);
  endtask

  // Called on a falling edge; asserts reset mid-cycle, holds it for n rising
  // edges, releases on a falling edge.
  task automatic do_reset(input int n);
    drive_idle();
    #2 rst_in = 1'b1;
    #1 chk_reset_vals();
    @(negedge clk_in);
    for (int k = 1; k < n; k++) begin
      #1 chk_reset_vals();
      @(negedge clk_in);
    end
    rst_in = 1'b0;
    model_reset();
    cyc_no = 0;
    $display("RESET released, cycles_held=%0d", n);
  endtask

  initial begin
    int w0, w1, w2, w3, w4, w5;
    cyc_t c;
    drive_idle();
    model_reset();
    @(negedge clk_in);

    // ---- program 1: ALU, stalled fetch, load, store, jump, illegal ----
    do_reset(3);
    add_instr(0, 0, 32'h0020_81B3, 0, 1, 0, 0, 0, 0, 32'h0000_0004, w0);
    add_instr(3, 2, 32'h0000_0013, 0, 1, 0, 0, 0, 0, 32'h0000_0008, w1);
    add_instr(0, 0, 32'h0000_A103, 0, 1, 1, 0, 2, 0, 32'h0000_000C, w2);
    add_instr(0, 0, 32'h0020_A023, 0, 0, 0, 1, 0, 1, 32'h0000_0010, w3);
    add_instr(0, 0, 32'hFF9F_F06F, 0, 1, 0, 0, 0, 0, 32'h0000_0008, w4);
    add_instr(0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 32'h0000_000C, w5);
    add_trap(20);
    // pin the timeline model against hand-counted latencies
    chk("lat_alu",   w0, 32'd5);
    chk("lat_stall", w1, 32'd10);
    chk("lat_load",  w2, 32'd9);
    chk("lat_store", w3, 32'd8);
    chk("lat_ill",   w5, 32'hFFFF_FFFF);
    run_tl(tl.size());
    $display("TXN prog1 retire_cycles=%0d,%0d,%0d,%0d,%0d illegal_at=8", w0, w1, w2, w3, w4);
    chk("p1_instret",  instret, 32'd5);
    chk("p1_pc",       pc, 32'h0000_0008);
    chk("p1_trap_pc",  trap_pc, 32'h0000_0008);
    chk("p1_cause",    {30'd0, trap_cause}, 32'd1);
    chk("p1_trap",     {31'd0, trap}, 32'd1);

    // ---- program 2: misaligned jump target ----
    do_reset(2);
    add_instr(0, 0, 32'h0060_006F, 0, 1, 0, 0, 0, 0, 32'h0000_0006, w0);
    add_trap(5);
    run_tl(tl.size());
    $display("TXN prog2 misaligned target 0x6 retire_cycle=%0d", w0);
    chk("p2_cause",   {30'd0, trap_cause}, 32'd2);
    chk("p2_pc",      pc, 32'h0000_0000);
    chk("p2_trap_pc", trap_pc, 32'h0000_0000);
    chk("p2_instret", instret, 32'd0);

    // ---- program 3: reset in MEM_WAIT, stray rvalids after release ----
    do_reset(2);
    add_instr(0, 0, 32'h0000_0013, 0, 1, 0, 0, 0, 0, 32'h0000_0020, w0);
    add_instr(0, 0, 32'h0000_A103, 0, 1, 1, 0, 0, 3, 32'h0000_0024, w1);
    run_tl(5 + 6);   // ALU, then load up to its first MEM_WAIT stall cycle
    tl.delete();
    drive_idle();
    #1 chk("p3_pre_rst_pc", pc, 32'h0000_0020);
    chk("p3_pre_rst_instret", instret, 32'd1);
    do_reset(2);
    add_instr(1, 0, 32'h0000_0013, 0, 1, 0, 0, 0, 0, 32'h0000_0004, w2);
    c = tl.pop_front();
    c.dmem_rvalid = 1'b1;
    c.imem_rvalid = 1'b1;
    tl.push_front(c);
    run_tl(tl.size());
    $display("TXN prog3 reset mid-load, refetch retire_cycle=%0d", w2);
    chk("p3_instret", instret, 32'd1);
    chk("p3_pc",      pc, 32'h0000_0004);
    chk("p3_retire_cycle", w2, 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the directed schedule is a few hundred cycles long.
  initial begin
    #20000;
    $display("FAIL watchdog simulation time limit reached actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cayde_ctrl.md
# cayde_ctrl

Multi-cycle sequencer for the cayde RISC-V core. Owns the PC and the instruction register, drives the instruction- and data-memory request handshakes, and steps each instruction through fetch, decode, execute, memory and writeback. It feeds the latched instruction to the decoder, consumes the decoder's classification flags, and gates ALU, register-file and memory activity. Illegal instructions and misaligned PC targets park the core in a sticky trap state.

## Interface
- BOOT_ADDR, 32'h0000_0000, PC value after reset.
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  32  fetch address; equals pc.
- imem_gnt  input  1  fetch request accepted.
- imem_rvalid  input  1  fetch data valid.
- imem_rdata  input  32  fetched instruction.
- instr  output  32  latched instruction to decoder.
- dec_illegal  input  1  decoder flags instr illegal.
- dec_rf_we  input  1  instr writes rd.
- dec_mem_rd  input  1  instr is a load.
- dec_mem_wr  input  1  instr is a store.
- pc_next  input  32  next PC from datapath (pc+4 or branch/jump target).
- alu_en  output  1  execute-stage enable.
- dmem_req  output  1  data memory request.
- dmem_we  output  1  data request is a store.
- dmem_gnt  input  1  data request accepted.
- dmem_rvalid  input  1  load data / store ack valid.
- rf_we  output  1  register-file write strobe.
- retire  output  1  one-cycle pulse per retired instruction.
- pc  output  32  current PC.
- instret  output  32  retired-instruction count.
- trap  output  1  sticky trap flag.
- trap_cause  output  2  01 illegal, 10 misaligned target, 00 none.
- trap_pc  output  32  PC of faulting instruction.

## Operation
- States: FETCH, FETCH_WAIT, DECODE, EXECUTE, MEM, MEM_WAIT, WRITEBACK, TRAP.
- Reset values: state=FETCH, pc=BOOT_ADDR, instr=32'h0000_0013 (NOP), instret=0, trap=0, trap_cause=00, trap_pc=0. While rst_in is high, all strobes (imem_req, dmem_req, dmem_we, alu_en, rf_we, retire) are 0.
- FETCH: imem_req=1, imem_addr=pc. On imem_gnt, go to FETCH_WAIT. Otherwise hold both outputs stable.
- FETCH_WAIT: on imem_rvalid, instr<=imem_rdata and go to DECODE. imem_rvalid is ignored in every other state.
- DECODE: one cycle. If dec_illegal, go to TRAP with cause 01; else go to EXECUTE.
- EXECUTE: alu_en=1 for one cycle. Go to MEM if dec_mem_rd|dec_mem_wr, else to WRITEBACK.
- MEM: dmem_req=1, dmem_we=dec_mem_wr, both held until dmem_gnt, then go to MEM_WAIT.
- MEM_WAIT: on dmem_rvalid, go to WRITEBACK. Stores also complete on dmem_rvalid.
- WRITEBACK:
  - If pc_next[1:0]!=0: rf_we=0, retire=0, pc unchanged, go to TRAP with cause 10.
  - Else: rf_we=dec_rf_we, retire=1, pc<=pc_next, instret<=instret+1 (wraps 0xFFFF_FFFF→0), go to FETCH.
- Entering TRAP: trap<=1, trap_cause latched, trap_pc<=pc. TRAP is absorbing; only reset leaves it. No requests are issued in TRAP.
- Decoder flags are sampled only from DECODE through WRITEBACK, while instr is stable.

## Timing
- Strobes are Moore decodes of the state register (plus dec_rf_we / dec_mem_wr). pc, instr, instret and the trap fields are registered.
- Minimum latency with gnt in the request cycle and rvalid the following cycle:
  - ALU instruction: 5 cycles, FETCH to next FETCH.
  - Load/store: 7 cycles.
- Each gnt or rvalid cycle of delay adds exactly one cycle.
- A reset asserted mid-instruction drops all strobes asynchronously. Late imem_rvalid or dmem_rvalid arriving after release is ignored; the first request after release uses BOOT_ADDR.
- retire and rf_we are coincident and last exactly one cycle.

## Test plan
- Reset: hold rst_in 3 cycles then release → imem_req=0 during reset; first cycle after release imem_req=1, imem_addr=0, pc=0, instret=0, trap=0.
- ALU op: gnt immediate, rvalid next cycle with 32'h0020_81B3, dec_rf_we=1, pc_next=4 → alu_en in cycle 4; rf_we=retire=1 in cycle 5; pc=4 and instret=1 afterward; next imem_addr=4.
- Stalls: imem_gnt low 3 cycles, then imem_rvalid delayed 2 cycles → imem_req and imem_addr held constant, instr unchanged until rvalid, retire at cycle 10.
- Load: dec_mem_rd=1, dmem_gnt delayed 2 cycles → dmem_req=1, dmem_we=0 held 3 cycles; retire one cycle after dmem_rvalid. Store repeat → dmem_we=1, rf_we=0 when dec_rf_we=0.
- Traps:
  - dec_illegal=1 at pc=0x8 → trap=1, trap_cause=01, trap_pc=0x8, no retire, imem_req stays 0 for 20 cycles.
  - Separately, pc_next=0x6 → trap_cause=10, rf_we=0, pc unchanged.
- Reset mid-MEM_WAIT, then a stray dmem_rvalid after release → no retire; FETCH resumes at BOOT_ADDR; instret=0.
